// File: rtl/sump_cmd_ctrl_if.sv
// Byte reply channel from the SUMP command sequencer
// to the UART transmitter (valid/ready handshake).
interface sump_cmd_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/sump_cmd_ctrl.sv
// SUMP command decoder, config registers, run/soft-reset control and reply sequencer.
// Optional metadata reply (opcode 0x04) enabled by defining SUMP_METADATA_EN.
module sump_cmd_ctrl #(
    parameter int STAGES    = 4,
    parameter int CH_WIDTH  = 32,
    parameter int MEM_DEPTH = 4096
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [39:0]                  cmd_i,
    input  logic                         cmd_stb_i,
    input  logic                         capture_done_i,
    sump_cmd_ctrl_if.master              tx,
    output logic [STAGES*CH_WIDTH-1:0]   trig_mask_o,
    output logic [STAGES*CH_WIDTH-1:0]   trig_val_o,
    output logic [STAGES*32-1:0]         trig_cfg_o,
    output logic [23:0]                  div_o,
    output logic [15:0]                  read_cnt_o,
    output logic [15:0]                  delay_cnt_o,
    output logic [31:0]                  flags_o,
    output logic                         run_o,
    output logic                         armed_o,
    output logic                         sreset_o
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        meta_q, meta_d;
    logic        run_q, armed_q, sreset_q;

    logic [STAGES*CH_WIDTH-1:0] mask_q, val_q;
    logic [STAGES*32-1:0]       cfg_q;
    logic [23:0]                div_q;
    logic [15:0]                read_q, delay_q;
    logic [31:0]                flags_q;

    logic        is_long;
    logic [7:0]  op;
    logic [31:0] arg;
    logic [31:0] stg;
    logic        long_stb, short_stb;
    logic        wr_div, wr_cnt, wr_flg, wr_mask, wr_val, wr_cfg;
    logic        do_sreset, do_run, do_id, do_meta;
    logic [3:0]  last_idx;
    logic        accept;

    always_comb begin
        is_long   = cmd_i[39];
        op        = is_long ? cmd_i[7:0] : cmd_i[39:32];
        arg       = cmd_i[39:8];
        stg       = {30'd0, op[3:2]};
        long_stb  = cmd_stb_i && is_long;
        short_stb = cmd_stb_i && !is_long;
        wr_div    = long_stb && (op == 8'h80);
        wr_cnt    = long_stb && (op == 8'h81);
        wr_flg    = long_stb && (op == 8'h82);
        // Trigger writes: 0b1100_ssff, ff = mask/value/config
        wr_mask   = long_stb && (op[7:4] == 4'hC) && (op[1:0] == 2'd0) && (stg < STAGES);
        wr_val    = long_stb && (op[7:4] == 4'hC) && (op[1:0] == 2'd1) && (stg < STAGES);
        wr_cfg    = long_stb && (op[7:4] == 4'hC) && (op[1:0] == 2'd2) && (stg < STAGES);
        do_sreset = short_stb && (op == 8'h00);
        do_run    = short_stb && (op == 8'h01);
        do_id     = short_stb && (op == 8'h02);
`ifdef SUMP_METADATA_EN
        do_meta   = short_stb && (op == 8'h04);
`else
        do_meta   = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q  <= '0;
            val_q   <= '0;
            cfg_q   <= '0;
            div_q   <= '0;
            read_q  <= '0;
            delay_q <= '0;
            flags_q <= '0;
        end else begin
            unique case (1'b1)
                wr_div:  div_q <= arg[23:0];
                wr_cnt: begin
                    read_q  <= arg[15:0];
                    delay_q <= arg[31:16];
                end
                wr_flg:  flags_q <= arg;
                wr_mask: mask_q[stg*CH_WIDTH +: CH_WIDTH] <= arg[CH_WIDTH-1:0];
                wr_val:  val_q[stg*CH_WIDTH +: CH_WIDTH]  <= arg[CH_WIDTH-1:0];
                wr_cfg:  cfg_q[stg*32 +: 32]              <= arg;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q    <= 1'b0;
            sreset_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            run_q    <= do_run;
            sreset_q <= do_sreset;
            // A run arriving with capture_done_i keeps the core armed
            if (do_run)
                armed_q <= 1'b1;
            else if (do_sreset || capture_done_i)
                armed_q <= 1'b0;
        end
    end

    assign last_idx = meta_q ? 4'd14 : 4'd3;
    assign accept   = tx.tx_valid && tx.tx_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        meta_d  = meta_q;
        unique case (state_q)
            IDLE: begin
                if (do_id || do_meta) begin
                    state_d = SEND;
                    idx_d   = 4'd0;
                    meta_d  = do_meta;
                end
            end
            SEND: begin
                if (accept) begin
                    if (idx_q == last_idx)
                        state_d = IDLE;
                    else
                        idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_sreset) begin
            state_d = IDLE;
            idx_d   = 4'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            meta_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            meta_q  <= meta_d;
        end
    end

`ifdef SUMP_METADATA_EN
    localparam logic [31:0] MD  = MEM_DEPTH;
    localparam logic [31:0] CW  = CH_WIDTH;

    function automatic logic [7:0] meta_byte(input logic [3:0] i);
        case (i)
            4'd0:    meta_byte = 8'h01;
            4'd1:    meta_byte = 8'h4C;
            4'd2:    meta_byte = 8'h6F;
            4'd3:    meta_byte = 8'h67;
            4'd4:    meta_byte = 8'h49;
            4'd5:    meta_byte = 8'h50;
            4'd6:    meta_byte = 8'h00;
            4'd7:    meta_byte = 8'h21;
            4'd8:    meta_byte = MD[31:24];
            4'd9:    meta_byte = MD[23:16];
            4'd10:   meta_byte = MD[15:8];
            4'd11:   meta_byte = MD[7:0];
            4'd12:   meta_byte = 8'h40;
            4'd13:   meta_byte = CW[7:0];
            default: meta_byte = 8'h00;
        endcase
    endfunction
`endif

    function automatic logic [7:0] id_byte(input logic [3:0] i);
        case (i)
            4'd0:    id_byte = 8'h31;
            4'd1:    id_byte = 8'h41;
            4'd2:    id_byte = 8'h4C;
            default: id_byte = 8'h53;
        endcase
    endfunction

    always_comb begin
        tx.tx_valid = (state_q == SEND);
`ifdef SUMP_METADATA_EN
        tx.tx_data  = meta_q ? meta_byte(idx_q) : id_byte(idx_q);
`else
        tx.tx_data  = id_byte(idx_q);
`endif
    end

    assign trig_mask_o = mask_q;
    assign trig_val_o  = val_q;
    assign trig_cfg_o  = cfg_q;
    assign div_o       = div_q;
    assign read_cnt_o  = read_q;
    assign delay_cnt_o = delay_q;
    assign flags_o     = flags_q;
    assign run_o       = run_q;
    assign armed_o     = armed_q;
    assign sreset_o    = sreset_q;

endmodule
